dispensador_troco: RTL and testbench

Change dispenser for the vending machine: the transmitting end of the coin-pulse interface. It accepts a change amount in 50-centavo units, drives a coin hopper with one-coin-at-a-time R (1 real) and C (50 centavos) pulses, and waits for the hopper's acknowledge after each coin. It sits between the sale controller, which issues the request, and the external hopper.

---
 rtl/dispensador_troco_pkg.sv | 38 +++
 rtl/dispensador_troco_if.sv | 24 ++
 rtl/dispensador_troco_contador_timeout.sv | 32 +++
 rtl/dispensador_troco.sv | 154 +++++++++++++++
 tb/tb_dispensador_troco.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dispensador_troco_pkg.sv
// Shared definitions for the change dispenser and the sale controller:
// state encoding, coin values and the coin-select encoding.
package dispensador_troco_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PULSE    = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    PULSE    = ST_PULSE,
    WAIT_ACK = ST_WAIT_ACK,
    DONE     = ST_DONE
  } state_t;

  // Coin values in 50-centavo units
  localparam int unsigned VAL_R = 2;
  localparam int unsigned VAL_C = 1;

  localparam logic COIN_C_ENC = 1'b0;
  localparam logic COIN_R_ENC = 1'b1;

  typedef enum logic {
    COIN_C = COIN_C_ENC,
    COIN_R = COIN_R_ENC
  } coin_t;

  function automatic int unsigned coin_value(coin_t coin);
    return (coin == COIN_R) ? VAL_R : VAL_C;
  endfunction

  // Greedy choice: largest coin that does not exceed what is still owed
  function automatic coin_t pick_coin(int unsigned rem);
    return (rem >= VAL_R) ? COIN_R : COIN_C;
  endfunction

endpackage

// File: rtl/dispensador_troco_if.sv
// Request / hopper-pulse bundle between the sale controller, the dispenser
// and the external coin hopper.
interface dispensador_troco_if #(
  parameter int unsigned AMT_W = 4
);
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             hop_ack;
  logic             R;
  logic             C;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output req, amount, hop_ack,
    input  R, C, busy, done, err
  );

  modport slave (
    input  req, amount, hop_ack,
    output R, C, busy, done, err
  );
endinterface

// File: rtl/dispensador_troco_contador_timeout.sv
// Loadable down-counter with a registered terminal-count flag; the flag is
// high while the count sits at zero.
module contador_timeout #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic         tc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b1;
    end else if (load_i) begin
      cnt_q <= load_val_i;
      tc_q  <= (load_val_i == '0);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
      tc_q  <= (cnt_q == W'(1));
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/dispensador_troco.sv
// Change dispenser: pays out `amount` (50-centavo units) as greedy R/C coin
// pulses to the hopper, one coin at a time, waiting for each acknowledge.
module dispensador_troco
  import dispensador_troco_pkg::*;
#(
  parameter int unsigned AMT_W     = 4,
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  dispensador_troco_if.slave    bus
);

  localparam int unsigned PW = $clog2(PULSE_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t           state_q;
  logic [AMT_W-1:0] rem_q;
  coin_t            coin_sel_q;
  logic             ack_seen_q;
  logic             r_q;
  logic             c_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [AMT_W-1:0] amount_c;
  logic [AMT_W-1:0] rem_after_c;
  logic [AMT_W-1:0] coin_src_c;
  coin_t            next_coin_c;
  logic             ack_any_c;
  logic             start_c;
  logic             next_coin_go_c;
  logic             pulse_load_c;
  logic             pulse_en_c;
  logic             to_load_c;
  logic             to_en_c;
  logic             pulse_tc;
  logic             to_tc;

  // Coin choice and counter control derived from the current state
  always_comb begin
    amount_c       = AMT_W'(bus.amount);
    ack_any_c      = ack_seen_q | bus.hop_ack;
    rem_after_c    = rem_q - AMT_W'(coin_value(coin_sel_q));
    coin_src_c     = (state_q == IDLE) ? amount_c : rem_after_c;
    next_coin_c    = pick_coin(32'(coin_src_c));
    start_c        = (state_q == IDLE) && bus.req && (amount_c != '0);
    next_coin_go_c = (state_q == WAIT_ACK) && ack_any_c && (rem_after_c != '0);
    pulse_load_c   = start_c | next_coin_go_c;
    pulse_en_c     = (state_q == PULSE);
    to_load_c      = (state_q == PULSE) && pulse_tc;
    to_en_c        = (state_q == WAIT_ACK);
  end

  contador_timeout #(.W(PW)) u_pulse_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pulse_load_c),
    .load_val_i (PW'(PULSE_LEN - 1)),
    .en_i       (pulse_en_c),
    .tc_o       (pulse_tc)
  );

  contador_timeout #(.W(TW)) u_timeout_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (to_load_c),
    .load_val_i (TW'(TIMEOUT - 1)),
    .en_i       (to_en_c),
    .tc_o       (to_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      coin_sel_q <= COIN_C;
      ack_seen_q <= 1'b0;
      r_q        <= 1'b0;
      c_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ack_seen_q <= 1'b0;
          if (bus.req) begin
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            rem_q  <= amount_c;
            if (amount_c == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= PULSE;
              coin_sel_q <= next_coin_c;
              r_q        <= (next_coin_c == COIN_R);
              c_q        <= (next_coin_c == COIN_C);
            end
          end
        end
        // An early ack is remembered but never shortens the pulse
        PULSE: begin
          if (bus.hop_ack) ack_seen_q <= 1'b1;
          if (pulse_tc) begin
            state_q <= WAIT_ACK;
            r_q     <= 1'b0;
            c_q     <= 1'b0;
          end
        end
        WAIT_ACK: begin
          if (ack_any_c) begin
            ack_seen_q <= 1'b0;
            rem_q      <= rem_after_c;
            if (rem_after_c == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= PULSE;
              coin_sel_q <= next_coin_c;
              r_q        <= (next_coin_c == COIN_R);
              c_q        <= (next_coin_c == COIN_C);
            end
          end else if (to_tc) begin
            ack_seen_q <= 1'b0;
            rem_q      <= '0;
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.R    = r_q;
  assign bus.C    = c_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_dispensador_troco.sv
// Scoreboard bench for dispensador_troco: expected hopper/handshake events are
// queued by the stimulus and matched by an independent output monitor.
module tb_dispensador_troco;

  localparam int K_R      = 1;
  localparam int K_C      = 2;
  localparam int K_DONE   = 3;
  localparam int K_ERR    = 4;
  localparam int K_BUSYLO = 5;
  localparam int K_ERRCLR = 6;

  typedef struct {
    int kind;
    int start;
    int len;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   base = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  sb[$];

  logic manual_ack = 1'b0;
  logic auto_mode  = 1'b1;
  int   auto_skip  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  dispensador_troco_if #(.AMT_W(4)) bus ();

  dispensador_troco #(
    .AMT_W     (4),
    .PULSE_LEN (2),
    .TIMEOUT   (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic string kname(int k);
    case (k)
      K_R:      return "R_pulse";
      K_C:      return "C_pulse";
      K_DONE:   return "done";
      K_ERR:    return "err_set";
      K_BUSYLO: return "busy_low";
      K_ERRCLR: return "err_clear";
      default:  return "unknown";
    endcase
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int s, input int l);
    ev_t e;
    e.kind  = k;
    e.start = s;
    e.len   = l;
    sb.push_back(e);
  endtask

  task automatic emit(input int k, input int s, input int l);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got start=%0d len=%0d, required no event", kname(k), s, l);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.start != s || e.len != l) begin
        errors++;
        $display("FAIL event_%s: got %s start=%0d len=%0d, required %s start=%0d len=%0d",
                 kname(e.kind), kname(k), s, l, kname(e.kind), e.start, e.len);
      end
    end
  endtask

  // Monitor: turns output activity into events, relative to the last accepted req
  initial begin : monitor
    logic pr, pc, pb, pe;
    int   rs, cs, rel;
    pr = 1'b0; pc = 1'b0; pb = 1'b0; pe = 1'b0;
    rs = 0; cs = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pr = 1'b0; pc = 1'b0; pb = 1'b0; pe = 1'b0;
      end else begin
        rel = edge_cnt - base;
        if (bus.R || bus.C) chk("no_overlap", bus.R & bus.C, 1'b0);
        if (!pr && bus.R) rs = rel;
        if (!pc && bus.C) cs = rel;
        if (pe && !bus.err) emit(K_ERRCLR, rel, 0);
        if (pr && !bus.R) emit(K_R, rs, rel - rs);
        if (pc && !bus.C) emit(K_C, cs, rel - cs);
        if (bus.done) begin
          emit(K_DONE, rel, 0);
          chk("busy_in_done", bus.busy, 1'b1);
        end
        if (!pe && bus.err) emit(K_ERR, rel, 0);
        if (pb && !bus.busy) emit(K_BUSYLO, rel, 0);
        pr = bus.R; pc = bus.C; pb = bus.busy; pe = bus.err;
      end
    end
  end

  // Hopper model: acks in the first cycle after a coin pulse ends
  initial begin : hopper
    logic prev_coin;
    logic fell;
    prev_coin   = 1'b0;
    bus.hop_ack = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      fell      = prev_coin && !(bus.R || bus.C) && !rst;
      prev_coin = (bus.R || bus.C) && !rst;
      if (fell && auto_skip > 0) begin
        auto_skip--;
        bus.hop_ack = manual_ack;
      end else begin
        bus.hop_ack = manual_ack | (auto_mode & fell);
      end
    end
  end

  task automatic start_req(input int amt);
    @(negedge clk);
    bus.req    = 1'b1;
    bus.amount = 4'(amt);
    base       = edge_cnt;
    @(negedge clk);
    bus.req    = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending events, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin : stimulus
    bus.req    = 1'b0;
    bus.amount = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_R", bus.R, 1'b0);
    chk("reset_C", bus.C, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_err", bus.err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of an R pulse truncates it immediately
    start_req(2);
    chk("pre_rst_R", bus.R, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_R", bus.R, 1'b0);
    chk("midrst_C", bus.C, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push(K_R, 1, 2); push(K_DONE, 4, 0); push(K_BUSYLO, 5, 0);
    start_req(2);
    wait_drain("amt2_after_rst", 50);

    // amount=3: one R then one C
    push(K_R, 1, 2); push(K_C, 4, 2); push(K_DONE, 7, 0); push(K_BUSYLO, 8, 0);
    start_req(3);
    wait_drain("amt3", 50);

    // amount=0: immediate done
    push(K_DONE, 1, 0); push(K_BUSYLO, 2, 0);
    start_req(0);
    wait_drain("amt0", 50);

    // amount=4 with ack arriving during the first pulse's second cycle
    push(K_R, 1, 2); push(K_R, 4, 2); push(K_DONE, 7, 0); push(K_BUSYLO, 8, 0);
    auto_skip = 1;
    start_req(4);
    @(negedge clk);
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    wait_drain("amt4_early_ack", 50);

    // amount=5 with a second req while busy, which must be ignored
    push(K_R, 1, 2); push(K_R, 4, 2); push(K_C, 7, 2);
    push(K_DONE, 10, 0); push(K_BUSYLO, 11, 0);
    start_req(5);
    bus.req    = 1'b1;
    bus.amount = 4'(1);
    @(negedge clk);
    bus.req    = 1'b0;
    wait_drain("amt5_busy_req", 60);

    // amount=1 with no ack: timeout after 255 WAIT_ACK cycles
    auto_mode = 1'b0;
    push(K_C, 1, 2); push(K_ERR, 258, 0); push(K_BUSYLO, 258, 0);
    start_req(1);
    wait_drain("amt1_timeout", 400);
    chk("err_sticky", bus.err, 1'b1);

    // Next accepted req clears err
    auto_mode = 1'b1;
    push(K_ERRCLR, 1, 0); push(K_DONE, 1, 0); push(K_BUSYLO, 2, 0);
    start_req(0);
    wait_drain("err_clear", 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
